// File: rtl/deco_suma_pkg.sv
// Shared types and width helpers for the sequential oversampled-bit summation block.
// Widths derive from window size N, chunk size CHUNK and chunk count NCHUNK.
package deco_suma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    // Width of a count of ones in an n-bit vector, including the all-ones case.
    function automatic int sum_w(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int cnt_w(input int chunk);
        return $clog2(chunk) + 1;
    endfunction

    function automatic int idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/deco_suma_seq_if.sv
// Window-in / sum-out handshake bundle for deco_suma_seq.
// The slave modport is the summation block; the master modport is its environment.
interface deco_suma_seq_if #(
    parameter int N     = 1024,
    parameter int SUM_W = deco_suma_pkg::sum_w(N)
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/deco_sum_chunk.sv
// Popcount of one CHUNK-bit slice of the window.
// Purely combinational, zero latency, no handshake.
module deco_sum_chunk
    import deco_suma_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]         bits,
    output logic [cnt_w(CHUNK)-1:0]  cnt
);
    localparam int CW = cnt_w(CHUNK);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt = cnt + {{(CW-1){1'b0}}, bits[i]};
        end
    end
endmodule

// File: rtl/deco_suma_seq.sv
// Counts the ones in a SAMPLES*OSF-bit window, CHUNK bits per cycle through one shared popcount.
// Latency NCHUNK cycles from accept to out_valid; one window in flight, in_ready low until the sum is taken.
// Optional DECOS_SUMA_THRESH_EN adds thresh input and registered out_hit = (sum >= thresh).
module deco_suma_seq
    import deco_suma_pkg::*;
#(
    parameter int SAMPLES = 128,
    parameter int OSF     = 8,
    parameter int CHUNK   = 8
) (
    input  logic                clk,
    input  logic                rst,
    deco_suma_seq_if.slave      bus,
`ifdef DECOS_SUMA_THRESH_EN
    input  logic [sum_w(SAMPLES*OSF)-1:0] thresh,
    output logic                out_hit,
`endif
    output logic                busy
);
    localparam int N      = SAMPLES * OSF;
    localparam int NCHUNK = N / CHUNK;
    localparam int SUM_W  = sum_w(N);
    localparam int CW     = cnt_w(CHUNK);
    localparam int IW     = idx_w(NCHUNK);

    state_t           state;
    logic [N-1:0]     win;
    logic [IW-1:0]    idx;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_nxt;
    logic [SUM_W-1:0] sum_q;
    logic             vld_q;
    logic             rdy_q;
    logic [CHUNK-1:0] chunk_bits;
    logic [CW-1:0]    cnt;
    logic             accept;

    assign accept     = (state == IDLE) && rdy_q && bus.in_valid;
    assign chunk_bits = win[idx*CHUNK +: CHUNK];
    assign acc_nxt    = acc + {{(SUM_W-CW){1'b0}}, cnt};

    deco_sum_chunk #(.CHUNK(CHUNK)) u_chunk (
        .bits (chunk_bits),
        .cnt  (cnt)
    );

    // Window contents are don't-care outside ACCUM, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (accept) begin
            win <= bus.in_data;
        end
    end

    // rdy_q mirrors "state is IDLE" but is held low during reset so in_ready stays low there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            idx     <= '0;
            sum_q   <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef DECOS_SUMA_THRESH_EN
            out_hit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        acc   <= '0;
                        idx   <= '0;
                        rdy_q <= 1'b0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_nxt;
                    idx <= idx + 1'b1;
                    if (idx == IW'(NCHUNK-1)) begin
                        sum_q   <= acc_nxt;
                        vld_q   <= 1'b1;
`ifdef DECOS_SUMA_THRESH_EN
                        out_hit <= (acc_nxt >= thresh);
`endif
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        vld_q <= 1'b0;
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    vld_q <= 1'b0;
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.out_sum   = sum_q;
    assign busy          = (state == ACCUM) || (state == DONE);

endmodule

// File: tb/tb_deco_suma_seq.sv
// Self-checking bench for deco_suma_seq: directed vector table, random windows against a
// popcount model, output stall, mid-window reset and back-to-back throughput.
module tb_deco_suma_seq;
    import deco_suma_pkg::*;

    localparam int SAMPLES = 128;
    localparam int OSF     = 8;
    localparam int CHUNK   = 8;
    localparam int N       = SAMPLES * OSF;
    localparam int NCHUNK  = N / CHUNK;
    localparam int SUM_W   = sum_w(N);

    logic clk = 1'b0;
    logic rst;
    logic busy;
    always #5 clk = ~clk;

    deco_suma_seq_if #(.N(N)) bus ();

`ifdef DECOS_SUMA_THRESH_EN
    logic [SUM_W-1:0] thresh;
    logic             out_hit;
`endif

    deco_suma_seq #(.SAMPLES(SAMPLES), .OSF(OSF), .CHUNK(CHUNK)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
`ifdef DECOS_SUMA_THRESH_EN
        .thresh  (thresh),
        .out_hit (out_hit),
`endif
        .busy    (busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] data;
        int           exp_sum;
        string        name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the number of ones in the window.
    function automatic int model_sum(input logic [N-1:0] w);
        return $countones(w);
    endfunction

    function automatic logic [N-1:0] rnd_win(input int mode);
        logic [N-1:0] w;
        logic [31:0]  r;
        for (int i = 0; i < N/32; i++) begin
            r = $urandom;
            if (mode == 1) r = r & $urandom & $urandom;
            else if (mode == 2) r = r | $urandom;
            w[i*32 +: 32] = r;
        end
        return w;
    endfunction

    task automatic wait_result(input string nm, output int n);
        n = 0;
        while (!bus.out_valid && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic run_window(input logic [N-1:0] d, input int exp, input string nm);
        int n;
        n = 0;
        while (!bus.in_ready && n < 500) begin
            tick();
            n++;
        end
        check({nm, " in_ready before accept"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        check({nm, " busy after accept"}, busy, 1);
        check({nm, " in_ready after accept"}, bus.in_ready, 0);
        wait_result(nm, n);
        check({nm, " latency"}, n, NCHUNK);
        check({nm, " out_sum"}, bus.out_sum, exp);
`ifdef DECOS_SUMA_THRESH_EN
        check({nm, " out_hit"}, out_hit, (exp >= int'(thresh)) ? 1 : 0);
`endif
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({nm, " out_valid drops"}, bus.out_valid, 0);
    endtask

    initial begin
        logic [N-1:0] wa, wb, tmp;
        int           ea, eb, n, t, last_t, got_cnt;
        logic [SUM_W-1:0] held;
        logic [N-1:0] bq[$];
        int           eq[$];

        vecs[0] = '{data: '0,                  exp_sum: 0,    name: "zeros"};
        vecs[1] = '{data: '1,                  exp_sum: 1024, name: "ones"};
        vecs[2] = '{data: {128{8'hAA}},        exp_sum: 512,  name: "aa"};
        vecs[3] = '{data: {128{8'h0F}},        exp_sum: 512,  name: "0f"};
        vecs[4] = '{data: {1'b1, 1023'b0},     exp_sum: 1,    name: "bit1023"};
        vecs[5] = '{data: {1023'b0, 1'b1},     exp_sum: 1,    name: "bit0"};
        vecs[6] = '{data: {128{8'h80}},        exp_sum: 128,  name: "msb_per_chunk"};
        vecs[7] = '{data: {{1016{1'b0}}, 8'hFF}, exp_sum: 8,  name: "first_chunk"};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef DECOS_SUMA_THRESH_EN
        thresh = '0;
`endif
        tick();
        tick();
        check("reset in_ready", bus.in_ready, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_sum", bus.out_sum, 0);
        check("reset busy", busy, 0);
`ifdef DECOS_SUMA_THRESH_EN
        check("reset out_hit", out_hit, 0);
`endif
        rst = 1'b0;
        tick();
        check("in_ready after reset", bus.in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_window(vecs[i].data, vecs[i].exp_sum, vecs[i].name);
        end

`ifdef DECOS_SUMA_THRESH_EN
        thresh = 512;
        run_window({128{8'hAA}}, 512, "aa_thresh512");
        thresh = 513;
        run_window({128{8'hAA}}, 512, "aa_thresh513");
`endif

        for (int i = 0; i < 6; i++) begin
            tmp = rnd_win(i % 3);
`ifdef DECOS_SUMA_THRESH_EN
            thresh = SUM_W'($urandom_range(0, N));
`endif
            run_window(tmp, model_sum(tmp), "random");
        end

        // Stall in DONE while a new window is offered.
        wa = rnd_win(0);
        wb = rnd_win(2);
        ea = model_sum(wa);
        eb = model_sum(wb);
        bus.in_valid = 1'b1;
        bus.in_data  = wa;
        tick();
        bus.in_data  = wb;
        wait_result("stall", n);
        check("stall latency", n, NCHUNK);
        held = bus.out_sum;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall out_valid", bus.out_valid, 1);
            check("stall out_sum", bus.out_sum, ea);
            check("stall out_sum held", bus.out_sum, held);
            check("stall in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("stall release out_valid", bus.out_valid, 0);
        check("stall release in_ready", bus.in_ready, 1);
        check("stall release busy", busy, 0);
        tick();
        bus.in_valid = 1'b0;
        check("stall new accept busy", busy, 1);
        check("stall new accept in_ready", bus.in_ready, 0);
        wait_result("stall second", n);
        check("stall second latency", n, NCHUNK);
        check("stall second out_sum", bus.out_sum, eb);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset in the middle of an all-ones window.
        bus.in_valid = 1'b1;
        bus.in_data  = '1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst busy", busy, 0);
        check("midrst in_ready", bus.in_ready, 0);
        check("midrst out_sum", bus.out_sum, 0);
        rst = 1'b0;
        tick();
        check("midrst in_ready after", bus.in_ready, 1);
        run_window({1'b1, 1023'b0}, 1, "after_rst_bit1023");

        // Back-to-back with both handshakes held high.
        for (int i = 0; i < 4; i++) begin
            tmp = rnd_win(i % 3);
            bq.push_back(tmp);
            eq.push_back(model_sum(tmp));
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = bq.pop_front();
        t = 0;
        last_t = -1;
        got_cnt = 0;
        while (got_cnt < 4 && t < 2000) begin
            logic acc_now;
            acc_now = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                check("b2b out_sum", bus.out_sum, eq.pop_front());
                if (last_t >= 0) check("b2b period", t - last_t, NCHUNK + 2);
                last_t = t;
                got_cnt++;
            end
            tick();
            t++;
            if (acc_now) begin
                if (bq.size() > 0) bus.in_data = bq.pop_front();
                else bus.in_valid = 1'b0;
            end
        end
        check("b2b result count", got_cnt, 4);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
